// File: rtl/jump_ctrl.sv
// jump_ctrl: multi-cycle jump/branch control FSM; JAL/JALR link support compiled in by JUMP_CTRL_LINK_EN
module jump_ctrl #(
  parameter logic [4:0] RA_INDEX = 5'd31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rd,
  input  logic       zero,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_sub,
  output logic       reg_write,
  output logic [4:0] link_reg,
  output logic       link_sel,
  output logic       busy,
  output logic       done,
  output logic       illegal
);
  typedef enum logic [2:0] {
    IDLE, CMP, UPDATE, DONE
`ifdef JUMP_CTRL_LINK_EN
    , LINK
`endif
  } state_t;
  state_t state;
  logic [5:0] op, fn;
  logic taken, in_j, in_upd, in_br, legal, br_taken;
  logic unused;
  assign in_j = opcode == 6'h02;
  assign in_upd = in_j || (opcode == 6'h00 && funct == 6'h08);
  assign in_br = opcode == 6'h04 || opcode == 6'h05;
  assign br_taken = op == 6'h05 ? ~zero : zero;
`ifdef JUMP_CTRL_LINK_EN
  logic [4:0] rd_q;
  logic in_link;
  assign in_link = opcode == 6'h03 || (opcode == 6'h00 && funct == 6'h09);
  assign legal = in_upd || in_br || in_link;
  assign unused = ^{rd_q, taken};
`else
  assign legal = in_upd || in_br;
  assign reg_write = 1'b0;
  assign link_reg = 5'd0;
  assign link_sel = 1'b0;
  assign unused = ^{rd, fn, taken};
`endif
  // state, latched instruction and the registered Moore outputs of the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op <= '0;
      fn <= '0;
      taken <= 1'b0;
      pc_write <= 1'b0;
      pc_src <= 2'b00;
      alu_sub <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      illegal <= 1'b0;
`ifdef JUMP_CTRL_LINK_EN
      rd_q <= '0;
      reg_write <= 1'b0;
      link_reg <= '0;
      link_sel <= 1'b0;
`endif
    end else begin
      pc_write <= 1'b0;
      pc_src <= 2'b00;
      alu_sub <= 1'b0;
      done <= 1'b0;
      illegal <= 1'b0;
`ifdef JUMP_CTRL_LINK_EN
      reg_write <= 1'b0;
      link_reg <= '0;
      link_sel <= 1'b0;
`endif
      case (state)
        IDLE: if (start) begin
          if (legal) begin
            op <= opcode;
            fn <= funct;
            taken <= 1'b0;
            busy <= 1'b1;
`ifdef JUMP_CTRL_LINK_EN
            rd_q <= rd;
`endif
          end
          if (in_upd) begin
            state <= UPDATE;
            pc_write <= 1'b1;
            pc_src <= in_j ? 2'b10 : 2'b11;
          end
`ifdef JUMP_CTRL_LINK_EN
          else if (in_link) begin
            state <= LINK;
            reg_write <= 1'b1;
            link_sel <= 1'b1;
            link_reg <= opcode == 6'h03 ? RA_INDEX : rd;
          end
`endif
          else if (in_br) begin
            state <= CMP;
            alu_sub <= 1'b1;
          end
          else illegal <= 1'b1;
        end
        CMP: begin
          state <= UPDATE;
          taken <= br_taken;
          pc_write <= br_taken;
          pc_src <= 2'b01;
        end
`ifdef JUMP_CTRL_LINK_EN
        LINK: begin
          state <= UPDATE;
          pc_write <= 1'b1;
          pc_src <= (op == 6'h00 && fn == 6'h09) ? 2'b11 : 2'b10;
        end
`endif
        UPDATE: begin
          state <= DONE;
          done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jump_ctrl.sv
// tb_jump_ctrl: directed and randomized checks of jump_ctrl against a per-cycle script model
module tb_jump_ctrl;
`ifdef JUMP_CTRL_LINK_EN
  localparam bit LINK_EN = 1'b1;
`else
  localparam bit LINK_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, zero = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic [4:0] rd = '0;
  logic pc_write, alu_sub, reg_write, link_sel, busy, done, illegal;
  logic [1:0] pc_src;
  logic [4:0] link_reg;
  int n_cmp = 0, n_err = 0;
  jump_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct(funct), .rd(rd), .zero(zero),
    .pc_write(pc_write), .pc_src(pc_src), .alu_sub(alu_sub), .reg_write(reg_write),
    .link_reg(link_reg), .link_sel(link_sel), .busy(busy), .done(done), .illegal(illegal)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic pw; logic [1:0] ps; logic as; logic rw; logic [4:0] lr; logic ls;
    logic bz; logic dn; logic il; logic cond; logic bne;
  } rec_t;
  rec_t q[$];
  rec_t cur;
  function automatic rec_t blank();
    rec_t r;
    r.pw = 1'b0; r.ps = 2'b00; r.as = 1'b0; r.rw = 1'b0; r.lr = 5'd0; r.ls = 1'b0;
    r.bz = 1'b0; r.dn = 1'b0; r.il = 1'b0; r.cond = 1'b0; r.bne = 1'b0;
    return r;
  endfunction
  // expands one accepted instruction into the outputs of each following cycle, ending with one IDLE cycle
  task automatic expand(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r);
    rec_t a, b;
    logic jr, jalr, ok;
    jr = o == 6'h00 && f == 6'h08;
    jalr = o == 6'h00 && f == 6'h09;
    a = blank();
    a.bz = 1'b1;
    b = a;
    ok = 1'b1;
    if (o == 6'h02 || jr) begin
      a.pw = 1'b1; a.ps = o == 6'h02 ? 2'b10 : 2'b11;
      q.push_back(a);
    end else if (LINK_EN && (o == 6'h03 || jalr)) begin
      a.rw = 1'b1; a.ls = 1'b1; a.lr = o == 6'h03 ? 5'd31 : r;
      b.pw = 1'b1; b.ps = o == 6'h03 ? 2'b10 : 2'b11;
      q.push_back(a); q.push_back(b);
    end else if (o == 6'h04 || o == 6'h05) begin
      a.as = 1'b1;
      b.cond = 1'b1; b.bne = o == 6'h05; b.ps = 2'b01;
      q.push_back(a); q.push_back(b);
    end else begin
      a.bz = 1'b0; a.il = 1'b1;
      q.push_back(a);
      ok = 1'b0;
    end
    if (ok) begin
      b = blank(); b.bz = 1'b1; b.dn = 1'b1;
      q.push_back(b);
      q.push_back(blank());
    end
  endtask
  // reference model: pops the script one cycle at a time, accepts start only with an empty script
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      cur = blank();
    end else if (q.size() != 0) begin
      cur = q.pop_front();
      if (cur.cond) cur.pw = cur.bne ? !zero : zero;
    end else if (start) begin
      expand(opcode, funct, rd);
      cur = q.pop_front();
    end else cur = blank();
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    check("outs", {pc_write, pc_src, alu_sub, reg_write, link_reg, link_sel, busy, done, illegal},
          {cur.pw, cur.ps, cur.as, cur.rw, cur.lr, cur.ls, cur.bz, cur.dn, cur.il});
    check("pw_rw_excl", {31'd0, pc_write & reg_write}, 32'd0);
  end
  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r, input logic z);
    @(negedge clk);
    start = 1'b1; opcode = o; funct = f; rd = r; zero = z;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  int dn;
  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_pc_src", pc_src, 0);
    reset = 1'b0; start = 1'b1; opcode = 6'h02;
    @(negedge clk);
    start = 1'b0;
    check("j_c1_pw", pc_write, 1);
    check("j_c1_src", pc_src, 2);
    @(negedge clk);
    check("j_c2_done", done, 1);
    @(negedge clk);
    check("j_c3_busy", busy, 0);
    issue(6'h03, 6'h00, 5'd0, 1'b0);
`ifdef JUMP_CTRL_LINK_EN
    check("jal_c1_rw", reg_write, 1);
    check("jal_c1_lr", link_reg, 31);
    check("jal_c1_ls", link_sel, 1);
    @(negedge clk);
    check("jal_c2_pw", pc_write, 1);
    check("jal_c2_src", pc_src, 2);
    @(negedge clk);
    check("jal_c3_done", done, 1);
`else
    check("jal_off_ill", illegal, 1);
    check("jal_off_busy", busy, 0);
`endif
    idle(2);
    issue(6'h04, 6'h00, 5'd0, 1'b1);
    check("beq_c1_sub", alu_sub, 1);
    @(negedge clk);
    check("beq_c2_pw", pc_write, 1);
    check("beq_c2_src", pc_src, 1);
    idle(2);
    issue(6'h05, 6'h00, 5'd0, 1'b1);
    @(negedge clk);
    check("bne_c2_pw", pc_write, 0);
    @(negedge clk);
    check("bne_c3_done", done, 1);
    idle(1);
    issue(6'h3F, 6'h00, 5'd0, 1'b0);
    check("ill_c1", illegal, 1);
    check("ill_c1_busy", busy, 0);
    @(negedge clk);
    check("ill_c2", illegal, 0);
    check("ill_c2_pw", pc_write, 0);
`ifdef JUMP_CTRL_LINK_EN
    issue(6'h00, 6'h09, 5'd5, 1'b0);
    check("jalr_c1_lr", link_reg, 5);
`else
    issue(6'h04, 6'h00, 5'd5, 1'b0);
`endif
    #2 reset = 1'b1;
    #1 check("rst_async", {pc_write, pc_src, alu_sub, reg_write, link_reg, link_sel, busy, done, illegal}, 0);
    @(negedge clk);
    reset = 1'b0;
    issue(6'h02, 6'h00, 5'd0, 1'b0);
    check("j2_c1_pw", pc_write, 1);
    @(negedge clk);
    check("j2_c2_done", done, 1);
    idle(2);
    dn = 0;
    start = 1'b1; opcode = 6'h04; zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dn += int'(done);
    end
    start = 1'b0;
    check("held_done_cnt", dn, 1);
    check("held_busy", busy, 0);
    idle(2);
    for (int i = 0; i < 800; i++) begin
      logic [5:0] ops [6];
      logic [5:0] fns [3];
      @(negedge clk);
      ops[0] = 6'h00; ops[1] = 6'h02; ops[2] = 6'h03; ops[3] = 6'h04; ops[4] = 6'h05;
      ops[5] = 6'($urandom);
      fns[0] = 6'h08; fns[1] = 6'h09; fns[2] = 6'($urandom);
      start = 1'($urandom_range(0, 1));
      opcode = ops[$urandom_range(0, 5)];
      funct = fns[$urandom_range(0, 2)];
      rd = 5'($urandom);
      zero = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 79) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    start = 1'b0;
    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
